// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex display driver.
// Scans DIGITS seven-segment digits over one shared segment bus. New values
// are captured into a shadow buffer and only copied into the displayed
// buffer at the end of a frame, so a frame never mixes old and new digits.
// All pin outputs are registered; ACTIVE_LOW selects the pin polarity.
module seven_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int   PCNT_W = $clog2(REFRESH_DIV);
    localparam int   IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Scan timing state
    logic [PCNT_W-1:0]   pcnt_reg, pcnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                tick;
    logic                wrap;

    // Double buffer
    logic [4*DIGITS-1:0] shadow_val_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic                pending_reg;
    logic [4*DIGITS-1:0] disp_val_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                commit;

    // Per-digit decode helpers
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   above_zero;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   onehot;

    // Registered pin drivers
    logic [6:0]          seg_reg, seg_next;
    logic                dp_reg, dp_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                fs_reg, fs_next;

    assign tick   = (pcnt_reg == PCNT_W'(REFRESH_DIV - 1));
    assign wrap   = tick && (idx_reg == IDX_W'(DIGITS - 1));
    assign commit = wrap && pending_reg;

    // Logical segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Split the displayed value into nibbles; a digit is blanked when it and
    // every more-significant nibble are zero (digit 0 always stays visible)
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]    = disp_val_reg[4*gi +: 4];
            assign onehot[gi] = (idx_reg == IDX_W'(gi));
            if (gi == DIGITS - 1) begin : g_top
                assign above_zero[gi] = (nib[gi] == 4'h0);
            end else begin : g_mid
                assign above_zero[gi] = (nib[gi] == 4'h0) && above_zero[gi+1];
            end
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_msd
                assign blank[gi] = lzb && above_zero[gi];
            end
        end
    endgenerate

    // Next prescaler count and digit index
    always_comb begin
        pcnt_next = tick ? '0 : PCNT_W'(pcnt_reg + 1'b1);
        idx_next  = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx_reg + 1'b1);
        end
    end

    // Prescaler and digit index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_reg <= '0;
            idx_reg  <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
            idx_reg  <= idx_next;
        end
    end

    // Shadow capture and end-of-frame commit; a load on the commit edge
    // stays pending so it lands at the following wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            disp_val_reg   <= '0;
            disp_dp_reg    <= '0;
        end else begin
            if (commit) begin
                disp_val_reg <= shadow_val_reg;
                disp_dp_reg  <= shadow_dp_reg;
            end
            if (load) begin
                shadow_val_reg <= in;
                shadow_dp_reg  <= dp_in;
                pending_reg    <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Pin values for the digit currently selected, with polarity applied
    always_comb begin
        seg_next = {7{POL}};
        dp_next  = POL;
        an_next  = {DIGITS{POL}};
        fs_next  = (pcnt_reg == '0) && (idx_reg == '0);
        if (enable) begin
            seg_next = (blank[idx_reg] ? 7'h00 : hex7(nib[idx_reg])) ^ {7{POL}};
            dp_next  = disp_dp_reg[idx_reg] ^ POL;
            an_next  = onehot ^ {DIGITS{POL}};
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_reg <= {7{POL}};
            dp_reg  <= POL;
            an_reg  <= {DIGITS{POL}};
            fs_reg  <= 1'b0;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
            fs_reg  <= fs_next;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan with DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
// Expected pin values are hand-computed (inverted segment codes).
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_val;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic        lzb;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int passed = 0;
    int total  = 0;

    seven_seg_scan #(
        .DIGITS(4),
        .REFRESH_DIV(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(in_val),
        .dp_in(dp_in),
        .load(load),
        .enable(enable),
        .lzb(lzb),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        lz;
        logic [27:0] segs;   // pin seg per digit {d3,d2,d1,d0}
        logic [3:0]  dps;    // pin dp per digit, bit k = digit k
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Step until frame_start is seen (checks the current sample first)
    task automatic wait_fs();
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
            step();
        end
        if (!found) check("wait_fs timeout", 32'd0, 32'd1);
    endtask

    // Check one whole frame starting at the current (frame start) sample
    task automatic scan(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        int         errs0;
        int         d;
        logic [3:0] one;
        logic [3:0] an_exp;
        errs0 = total - passed;
        one   = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            d      = c / 4;
            an_exp = ~(one << d);
            check($sformatf("%s d%0d c%0d an", tag, d, c), {28'd0, an}, {28'd0, an_exp});
            check($sformatf("%s d%0d c%0d seg", tag, d, c), {25'd0, seg}, {25'd0, segs[d*7 +: 7]});
            check($sformatf("%s d%0d c%0d dp", tag, d, c), {31'd0, dp}, {31'd0, dps[d]});
            check($sformatf("%s c%0d frame_start", tag, c), {31'd0, frame_start},
                  {31'd0, (c == 0)});
            step();
        end
        $display("frame %s: errors=%0d", tag, (total - passed) - errs0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_fs;
        int second_fs;
        bit an_bad;

        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h0040, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b0111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0040, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1111};
        vecs[4] = '{16'h1000, 4'b0000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[5] = '{16'h0305, 4'b0001, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'b1110};
        vecs[6] = '{16'h00B0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h03, 7'h40}, 4'b1111};
        vecs[7] = '{16'h89CE, 4'b0000, 1'b0, {7'h00, 7'h10, 7'h46, 7'h06}, 4'b1111};
        vecs[8] = '{16'h67D3, 4'b0000, 1'b0, {7'h02, 7'h78, 7'h21, 7'h30}, 4'b1111};

        reset  = 1'b1;
        in_val = 16'h0;
        dp_in  = 4'h0;
        load   = 1'b0;
        enable = 1'b1;
        lzb    = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset dp", {31'd0, dp}, 32'h1);
        check("reset an", {28'd0, an}, 32'hF);
        check("reset frame_start", {31'd0, frame_start}, 32'h0);
        $display("reset: seg=%h dp=%b an=%h fs=%b", seg, dp, an, frame_start);

        reset = 1'b0;
        step();
        check("release an", {28'd0, an}, 32'hE);
        check("release frame_start", {31'd0, frame_start}, 32'h1);
        check("release seg", {25'd0, seg}, 32'h40);
        $display("release: seg=%h dp=%b an=%h fs=%b", seg, dp, an, frame_start);

        // Table: load at a frame start, show it from the next frame
        for (int v = 0; v < 9; v++) begin
            in_val = vecs[v].val;
            dp_in  = vecs[v].dpi;
            lzb    = vecs[v].lz;
            load   = 1'b1;
            step();
            load   = 1'b0;
            wait_fs();
            scan($sformatf("vec%0d_%h_lzb%0b", v, vecs[v].val, vecs[v].lz),
                 vecs[v].segs, vecs[v].dps);
        end

        // Tear-free update: two loads mid-frame, old frame undisturbed
        dp_in = 4'h0;
        lzb   = 1'b0;
        repeat (4) step();                     // internal idx = 1
        in_val = 16'h1111; load = 1'b1; step(); load = 1'b0;
        repeat (3) step();                     // internal idx = 2
        in_val = 16'h2222; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();                     // presenting digit 3
        check("tearfree old an", {28'd0, an}, 32'h7);
        check("tearfree old seg", {25'd0, seg}, 32'h02);
        $display("tearfree mid-frame: an=%h seg=%h", an, seg);
        wait_fs();
        scan("tearfree_2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

        // Load on the commit edge: 5555 shown first, 7777 one frame later
        repeat (2) step();
        in_val = 16'h5555; load = 1'b1; step(); load = 1'b0;
        repeat (11) step();                    // last cycle before the wrap edge
        in_val = 16'h7777; load = 1'b1; step(); load = 1'b0;
        step();
        scan("coincide_5555", {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111);
        scan("coincide_7777", {7'h78, 7'h78, 7'h78, 7'h78}, 4'b1111);

        // Enable off mid-frame: pins go inactive, frame_start keeps pulsing
        repeat (5) step();
        enable = 1'b0;
        step();                                // c = 6
        check("disable an", {28'd0, an}, 32'hF);
        check("disable seg", {25'd0, seg}, 32'h7F);
        check("disable dp", {31'd0, dp}, 32'h1);
        first_fs  = -1;
        second_fs = -1;
        an_bad    = 0;
        for (int c = 7; c <= 40; c++) begin
            step();
            if (an !== 4'hF || seg !== 7'h7F) an_bad = 1;
            if (frame_start === 1'b1) begin
                if (first_fs < 0) first_fs = c;
                else if (second_fs < 0) second_fs = c;
            end
            if (second_fs >= 0) break;
        end
        check("disable pins stay off", {31'd0, an_bad}, 32'd0);
        check("disable first frame_start", first_fs, 32'd16);
        check("disable second frame_start", second_fs, 32'd32);
        $display("disable: frame_start at %0d and %0d", first_fs, second_fs);
        enable = 1'b1;
        step();
        check("reenable an", {28'd0, an}, 32'hE);
        check("reenable seg", {25'd0, seg}, 32'h78);
        $display("reenable: an=%h seg=%h", an, seg);

        // Reset while a load is pending discards it
        in_val = 16'h9999; load = 1'b1; step(); load = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check("midreset an", {28'd0, an}, 32'hF);
        reset = 1'b0;
        step();
        check("postreset an", {28'd0, an}, 32'hE);
        check("postreset seg", {25'd0, seg}, 32'h40);
        check("postreset frame_start", {31'd0, frame_start}, 32'h1);
        $display("postreset: an=%h seg=%h fs=%b", an, seg, frame_start);
        scan("postreset_f0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        scan("postreset_f1", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed hex display driver. It drives DIGITS seven-segment digits that share one segment bus, enabling one digit at a time at a programmable refresh rate. It adds double-buffered loading (tear-free frame updates), per-digit decimal points, leading-zero blanking, selectable output polarity and a frame-start strobe. It sits between the datapath (value producer) and the board display pins.

## Interface
- DIGITS, 4: number of digits, legal range 1..8.
- REFRESH_DIV, 50000: clock cycles each digit stays lit, minimum 2.
- ACTIVE_LOW, 1: 1 inverts seg, dp and an at the pins; 0 drives active-high.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  4*DIGITS  hex value; nibble k (in[4k+3:4k]) is digit k; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit; bit k is digit k.
- load  in  1  one-cycle capture strobe for in/dp_in.
- enable  in  1  1 = display on; 0 = all outputs inactive, counters keep running.
- lzb  in  1  leading-zero blanking enable.
- seg  out  7  segment bus, bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point of the digit being driven.
- an  out  DIGITS  digit enables, one-hot when active.
- frame_start  out  1  one-cycle pulse when digit 0 is first presented in a frame.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps; tick = (pcnt == REFRESH_DIV-1).
- Digit index `idx` advances on tick: 0,1,..,DIGITS-1,0.
- Shadow register: on load, shadow <= {in, dp_in} and pending <= 1.
- Commit: on a tick where idx == DIGITS-1 (wrap) and pending == 1, display <= shadow and pending <= 0.
- Load coincident with commit: display takes the pre-load shadow, shadow takes the new value, pending stays 1, so the new value commits at the next wrap.
- Decode (logical, before polarity), digits 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking: when lzb=1, digit k>0 is blanked (seg all off) if nibbles DIGITS-1..k of display are all zero. Digit 0 is never blanked. A blanked digit keeps its anode and its dp.
- Driven values: an = one-hot(idx), seg = decode or blank, dp = display dp[idx]. If enable=0, an, seg and dp are all inactive.
- Polarity: when ACTIVE_LOW=1, the final seg, dp and an are bitwise inverted. frame_start is always active-high.
- DIGITS=1: idx is constant 0, every tick is a wrap, and frame_start pulses every REFRESH_DIV cycles.

## Timing
- Reset values: pcnt=0, idx=0, shadow=0, display=0, pending=0, frame_start=0. seg, dp and an are inactive: all 1 for ACTIVE_LOW=1, all 0 for ACTIVE_LOW=0.
- Reset has priority over load, tick and enable. Reset mid-frame discards the shadow and any pending value.
- seg, an, dp and frame_start are registered, with one cycle of latency from idx, display and enable/lzb.
- Digit k is presented for exactly REFRESH_DIV cycles. One frame lasts DIGITS*REFRESH_DIV cycles.
- frame_start is high in the first cycle that presents digit 0 after a wrap, and also in the first cycle after reset release.
- Load-to-visible latency: from the load edge to the next wrap tick plus 1 cycle. At most DIGITS*REFRESH_DIV+1 cycles.
- Multiple loads within one frame: the last one wins, and only it is committed.
- Toggling enable does not disturb pcnt, idx, pending or display. Outputs reflect enable after 1 cycle.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
- Reset: hold reset 3 cycles -> seg=7F, dp=1, an=F. First cycle after release: an=E and frame_start=1.
- Scan: load in=16'h12AF, dp_in=4'b0100, then wait one frame -> an cycles E,D,B,7 with 4 cycles each, seg=0E (F), 08 (A), 24 (2), 79 (1), and dp=0 only while an=B.
- Tear-free update: load 16'h1111 at idx=1, then load 16'h2222 at idx=2 -> no mixed frame appears; the next frame shows all digits as 2 (seg=24).
- Load coincident with commit tick: display keeps the old shadow for one frame, and the new value appears in the following frame.
- Leading-zero blanking: display 16'h0040 with lzb=1 -> digits 3 and 2 show seg=7F with their anodes active, digit 1 shows 19, digit 0 shows 40. Display 16'h0000 -> only digit 0 shows 40.
- Enable and reset interplay: enable=0 mid-frame -> an=F and seg=7F the next cycle, while frame_start keeps pulsing every 16 cycles. Reset asserted while pending=1 -> display stays 0 after release.
